fetch_sequencer: RTL and testbench
==================================

# fetch_sequencer

Instruction-fetch controller that owns the program counter and sequences instruction-memory requests for the RV32I core. It issues word fetches over a req/ack handshake to the instruction memory and buffers returned instructions in a 2-entry queue. It presents them to decode over a valid/ready handshake. It applies redirects from execute (taken branch, jal, jalr) and discards any in-flight or buffered wrong-path instructions.

## Interface
- WIDTH, 32, address/PC width
- RESET_PC, 32'h0000_0000, first fetch address after reset
- clk  in  1  clock; all state updates on posedge
- rst  in  1  reset; synchronous and active-high
- redirect_valid  in  1  execute resolved a control transfer this cycle
- redirect_pc  in  WIDTH  target; bits [1:0] forced to 0 internally
- imem_req  out  1  fetch request
- imem_addr  out  WIDTH  fetch address; word-aligned
- imem_ack  in  1  request completed; imem_rdata valid this cycle
- imem_rdata  in  32  fetched instruction
- instr_valid  out  1  buffered instruction available to decode
- instr  out  32  instruction at queue head
- instr_pc  out  WIDTH  address of instr
- instr_ready  in  1  decode accepts head this cycle
- pc  out  WIDTH  address of next new fetch

## Operation
- Reset values: state IDLE, pc=RESET_PC, queue count=0, imem_req=0, imem_addr=0, instr_valid=0, instr=0, instr_pc=0.
- States:
  - IDLE: next state is always FETCH.
  - FETCH: imem_req = (count<2); imem_addr=pc.
  - KILL: imem_req=1; imem_addr=kill_addr.
- Request stability: once imem_req is asserted, it stays high and imem_addr stays constant until the imem_ack cycle. This holds because count cannot rise while a request is pending.
- FETCH, ack, no redirect:
  - push {pc, imem_rdata} into the queue.
  - pc <= pc+4, wrapping modulo 2^WIDTH.
  - stay in FETCH.
- Pop: occurs when instr_valid && instr_ready. Push and pop in the same cycle leave count unchanged.
- Redirect has priority over push, pop and ack in every state except IDLE:
  - flush the queue (count<=0).
  - pc <= {redirect_pc[WIDTH-1:2],2'b00}.
  - ack data received in the same cycle is discarded.
- Redirect in FETCH:
  - with imem_req=1 and no ack: kill_addr<=imem_addr, go to KILL.
  - otherwise: stay in FETCH.
- KILL:
  - on ack: discard data, go to FETCH.
  - on redirect: update pc only, stay in KILL.
- Redirect in IDLE: pc updated; transition to FETCH as normal.
- Reset asserted mid-operation, including with a request outstanding: state returns to reset values the next cycle. Any later ack is ignored until FETCH issues a new request.
- Only one memory request is ever outstanding.

## Timing
- Let cycle 0 be the first cycle with rst low.
  - cycle 0: state IDLE.
  - cycle 1: imem_req=1, imem_addr=RESET_PC.
- Zero-wait memory (ack in the same cycle as req) is supported. Throughput is then one instruction per cycle with instr_ready held high.
- Ack at cycle t gives instr_valid at t+1, when the queue was empty.
- Redirect at cycle t, no pending request at t: instr_valid=0 and imem_addr=target at t+1.
- Redirect at cycle t, pending request at t: imem_addr holds the killed address until its ack. The target is issued the cycle after that ack.
- instr, instr_pc and instr_valid are registered queue outputs with no combinational path from imem_*.
- instr_ready -> imem_req: one combinational path through count is allowed.

## Structure
- fetch_pkg holds:
  - typedef enum logic [1:0] fetch_state_t {IDLE, FETCH, KILL}.
  - localparam INSTR_BYTES=4.
  - localparam FETCH_Q_DEPTH=2.
- Sub-module fetch_fifo: 2-entry queue of {pc, instr}.
  - ports: push, pop, flush (flush dominates), count, head outputs.
  - synchronous reset.
- fetch_sequencer contains the FSM, the pc register, the kill_addr register and the redirect alignment logic.

## Test plan
1. Reset: RESET_PC=32'h100, rst high 3 cycles with imem_ack toggling. Required:
   - all outputs 0 while rst is high.
   - cycle 0 after release: imem_req=0.
   - cycle 1: imem_req=1, imem_addr=32'h100.
2. Streaming: ack every cycle, instr_ready=1, rdata=addr^32'hA5A5_A5A5. Required: instr_pc = 0x100, 0x104, 0x108, … on consecutive cycles with no bubbles, and instr matches.
3. Backpressure: instr_ready=0 from cycle 1. Required:
   - exactly two acks are accepted (0x100, 0x104).
   - imem_req drops with pc=0x108.
   - raising instr_ready pops 0x100 then 0x104 in order.
   - fetch resumes at 0x108.
4. Killed request: ack delayed 3 cycles on 0x108, redirect to 32'h200 on the first wait cycle. Required:
   - imem_addr stays 0x108 until its ack.
   - that data never appears on instr.
   - instr_valid=0 after the redirect.
   - next request is addressed 0x200.
5. Redirect coincident with ack of 0x10C, redirect_pc=32'h203. Required:
   - 0x10C data is discarded.
   - next cycle imem_req=1 with imem_addr=0x200.
   - the queue is empty.
6. Wrap: redirect to 32'hFFFF_FFFC with streaming acks. Required: instr_pc = FFFF_FFFC then 0000_0000.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package fetch_pkg;

   typedef enum logic [1:0] {
      IDLE,
      FETCH,
      KILL
   } fetch_state_t;

   localparam int INSTR_BYTES   = 4;
   localparam int FETCH_Q_DEPTH = 2;

endpackage

// File: rtl/fetch_sequencer_if.sv
// Signal bundle between the fetch sequencer, instruction memory, execute and decode.
interface fetch_sequencer_if #(
   parameter int WIDTH = 32
);

   logic             redirect_valid;
   logic [WIDTH-1:0] redirect_pc;
   logic             imem_req;
   logic [WIDTH-1:0] imem_addr;
   logic             imem_ack;
   logic [31:0]      imem_rdata;
   logic             instr_valid;
   logic [31:0]      instr;
   logic [WIDTH-1:0] instr_pc;
   logic             instr_ready;
   logic [WIDTH-1:0] pc;

   modport master (
      input  redirect_valid, redirect_pc, imem_ack, imem_rdata, instr_ready,
      output imem_req, imem_addr, instr_valid, instr, instr_pc, pc
   );

   modport slave (
      output redirect_valid, redirect_pc, imem_ack, imem_rdata, instr_ready,
      input  imem_req, imem_addr, instr_valid, instr, instr_pc, pc
   );

endinterface

// File: rtl/fetch_fifo.sv
// Two-entry in-order queue of {pc, instr}; slot 0 is always the head.
module fetch_fifo
   import fetch_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push_i,
   input  logic             pop_i,
   input  logic             flush_i,
   input  logic [WIDTH-1:0] wr_pc_i,
   input  logic [31:0]      wr_instr_i,
   output logic [1:0]       count_o,
   output logic [WIDTH-1:0] head_pc_o,
   output logic [31:0]      head_instr_o
);

   logic [WIDTH-1:0] pc_q    [FETCH_Q_DEPTH];
   logic [WIDTH-1:0] pc_d    [FETCH_Q_DEPTH];
   logic [31:0]      instr_q [FETCH_Q_DEPTH];
   logic [31:0]      instr_d [FETCH_Q_DEPTH];
   logic [1:0]       count_q;
   logic [1:0]       count_d;
   logic             do_pop;
   logic             do_push;
   logic             wr_slot;

   assign do_pop  = pop_i && (count_q != 2'd0);
   assign do_push = push_i && ((count_q != 2'(FETCH_Q_DEPTH)) || do_pop);
   // Write lands just behind the surviving entries after this cycle's pop.
   assign wr_slot = do_pop ? (count_q == 2'd2) : (count_q == 2'd1);

   always_comb begin
      count_d = count_q;
      pc_d    = pc_q;
      instr_d = instr_q;
      if (flush_i) begin
         count_d = 2'd0;
      end else begin
         if (do_pop) begin
            pc_d[0]    = pc_q[1];
            instr_d[0] = instr_q[1];
         end
         if (do_push) begin
            pc_d[wr_slot]    = wr_pc_i;
            instr_d[wr_slot] = wr_instr_i;
         end
         count_d = count_q + {1'b0, do_push} - {1'b0, do_pop};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= 2'd0;
         for (int i = 0; i < FETCH_Q_DEPTH; i++) begin
            pc_q[i]    <= '0;
            instr_q[i] <= '0;
         end
      end else begin
         count_q <= count_d;
         pc_q    <= pc_d;
         instr_q <= instr_d;
      end
   end

   assign count_o      = count_q;
   assign head_pc_o    = pc_q[0];
   assign head_instr_o = instr_q[0];

endmodule

// File: rtl/fetch_sequencer.sv
// Owns the PC, issues one word fetch at a time and drops wrong-path fetches on redirect.
module fetch_sequencer
   import fetch_pkg::*;
#(
   parameter int               WIDTH    = 32,
   parameter logic [WIDTH-1:0] RESET_PC = '0
) (
   input  logic           clk,
   input  logic           rst,
   fetch_sequencer_if.master bus
);

   fetch_state_t     state_q, state_d;
   logic [WIDTH-1:0] pc_q, pc_d;
   logic [WIDTH-1:0] kill_addr_q, kill_addr_d;
   logic [WIDTH-1:0] target;
   logic             req;
   logic [WIDTH-1:0] addr;
   logic             push;
   logic             pop;
   logic             flush;
   logic [1:0]       count;
   logic             instr_valid;

   assign target      = bus.redirect_pc & ~WIDTH'(INSTR_BYTES - 1);
   assign instr_valid = (count != 2'd0);
   assign pop         = instr_valid && bus.instr_ready;

   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      kill_addr_d = kill_addr_q;
      req         = 1'b0;
      addr        = '0;
      push        = 1'b0;
      flush       = 1'b0;
      case (state_q)
         IDLE: begin
            state_d = FETCH;
            if (bus.redirect_valid) pc_d = target;
         end
         FETCH: begin
            req  = (count < 2'(FETCH_Q_DEPTH));
            addr = pc_q;
            if (bus.redirect_valid) begin
               flush = 1'b1;
               pc_d  = target;
               // An unacked request cannot be withdrawn; wait out its ack in KILL.
               if (req && !bus.imem_ack) begin
                  kill_addr_d = pc_q;
                  state_d     = KILL;
               end
            end else if (req && bus.imem_ack) begin
               push = 1'b1;
               pc_d = pc_q + WIDTH'(INSTR_BYTES);
            end
         end
         KILL: begin
            req  = 1'b1;
            addr = kill_addr_q;
            if (bus.redirect_valid) begin
               flush = 1'b1;
               pc_d  = target;
            end
            if (bus.imem_ack) state_d = FETCH;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         pc_q        <= RESET_PC;
         kill_addr_q <= '0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         kill_addr_q <= kill_addr_d;
      end
   end

   fetch_fifo #(
      .WIDTH(WIDTH)
   ) u_fifo (
      .clk          (clk),
      .rst          (rst),
      .push_i       (push),
      .pop_i        (pop),
      .flush_i      (flush),
      .wr_pc_i      (pc_q),
      .wr_instr_i   (bus.imem_rdata),
      .count_o      (count),
      .head_pc_o    (bus.instr_pc),
      .head_instr_o (bus.instr)
   );

   assign bus.imem_req    = req;
   assign bus.imem_addr   = addr;
   assign bus.instr_valid = instr_valid;
   assign bus.pc          = pc_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: reset, streaming, backpressure, kill, redirect-with-ack, wrap.
module tb_fetch_sequencer;

   localparam logic [31:0] K = 32'hA5A5_A5A5;

   logic clk;
   logic rst;
   int   checks = 0;
   int   errors = 0;

   fetch_sequencer_if #(.WIDTH(32)) bus ();

   fetch_sequencer #(
      .WIDTH    (32),
      .RESET_PC (32'h0000_0100)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      $display("%0t %s obs=%h exp=%h", $time, tag, obs, exp);
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Leaves the bench in cycle 1 (first request visible), with ack low.
   task automatic do_reset();
      rst                = 1'b1;
      bus.redirect_valid = 1'b0;
      bus.instr_ready    = 1'b0;
      bus.imem_ack       = 1'b1;
      bus.imem_rdata     = 32'hBAD0_0000;
      tick();
      #1;
      chk("rst_mid_req", {31'd0, bus.imem_req}, 32'd0);
      chk("rst_mid_valid", {31'd0, bus.instr_valid}, 32'd0);
      chk("rst_mid_pc", bus.pc, 32'h100);
      tick();
      rst = 1'b0;
      #1;
      chk("c0_req", {31'd0, bus.imem_req}, 32'd0);
      tick();
      bus.imem_ack = 1'b0;
      #1;
      chk("c1_req", {31'd0, bus.imem_req}, 32'd1);
      chk("c1_addr", bus.imem_addr, 32'h100);
      chk("c1_valid", {31'd0, bus.instr_valid}, 32'd0);
   endtask

   initial begin
      // ---- 1: reset with ack toggling
      rst                = 1'b1;
      bus.redirect_valid = 1'b0;
      bus.redirect_pc    = 32'd0;
      bus.imem_ack       = 1'b0;
      bus.imem_rdata     = 32'h1234_5678;
      bus.instr_ready    = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         bus.imem_ack = i[0];
         #1;
         chk("rst_req", {31'd0, bus.imem_req}, 32'd0);
         chk("rst_addr", bus.imem_addr, 32'd0);
         chk("rst_valid", {31'd0, bus.instr_valid}, 32'd0);
         chk("rst_instr", bus.instr, 32'd0);
         chk("rst_instr_pc", bus.instr_pc, 32'd0);
         chk("rst_pc", bus.pc, 32'h100);
      end
      rst          = 1'b0;
      bus.imem_ack = 1'b1;            // stray ack in IDLE must be ignored
      #1;
      chk("t1_c0_req", {31'd0, bus.imem_req}, 32'd0);
      tick();
      bus.imem_ack = 1'b0;
      #1;
      chk("t1_c1_req", {31'd0, bus.imem_req}, 32'd1);
      chk("t1_c1_addr", bus.imem_addr, 32'h100);
      chk("t1_c1_valid", {31'd0, bus.instr_valid}, 32'd0);

      // ---- 2: streaming, zero-wait acks, no bubbles
      bus.instr_ready = 1'b1;
      for (int k = 0; k < 6; k++) begin
         if (k > 0) tick();
         bus.imem_ack   = 1'b1;
         bus.imem_rdata = (32'h100 + 32'(4 * k)) ^ K;
         #1;
         chk("t2_req", {31'd0, bus.imem_req}, 32'd1);
         chk("t2_addr", bus.imem_addr, 32'h100 + 32'(4 * k));
         if (k > 0) begin
            chk("t2_valid", {31'd0, bus.instr_valid}, 32'd1);
            chk("t2_instr_pc", bus.instr_pc, 32'h100 + 32'(4 * (k - 1)));
            chk("t2_instr", bus.instr, (32'h100 + 32'(4 * (k - 1))) ^ K);
         end
      end
      tick();
      bus.imem_ack = 1'b0;
      #1;
      chk("t2_last_pc", bus.instr_pc, 32'h114);
      chk("t2_last_instr", bus.instr, 32'h114 ^ K);

      // ---- 3: backpressure (reset with a request for 0x118 outstanding)
      do_reset();
      bus.imem_ack   = 1'b1;
      bus.imem_rdata = 32'h100 ^ K;
      tick();                                  // cycle 2
      bus.imem_rdata = 32'h104 ^ K;
      #1;
      chk("t3_c2_addr", bus.imem_addr, 32'h104);
      chk("t3_c2_instr_pc", bus.instr_pc, 32'h100);
      tick();                                  // cycle 3: queue full
      #1;
      chk("t3_c3_req", {31'd0, bus.imem_req}, 32'd0);
      chk("t3_c3_pc", bus.pc, 32'h108);
      tick();                                  // cycle 4
      bus.instr_ready = 1'b1;
      #1;
      chk("t3_c4_req", {31'd0, bus.imem_req}, 32'd0);
      chk("t3_c4_pc", bus.pc, 32'h108);
      chk("t3_c4_instr_pc", bus.instr_pc, 32'h100);
      chk("t3_c4_instr", bus.instr, 32'h100 ^ K);
      tick();                                  // cycle 5: first wait on 0x108
      bus.imem_ack       = 1'b0;
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = 32'h200;
      #1;
      chk("t3_c5_instr_pc", bus.instr_pc, 32'h104);
      chk("t3_c5_instr", bus.instr, 32'h104 ^ K);
      chk("t3_c5_req", {31'd0, bus.imem_req}, 32'd1);
      chk("t3_c5_addr", bus.imem_addr, 32'h108);

      // ---- 4: killed request
      tick();                                  // cycle 6
      bus.redirect_valid = 1'b0;
      #1;
      chk("t4_c6_addr", bus.imem_addr, 32'h108);
      chk("t4_c6_valid", {31'd0, bus.instr_valid}, 32'd0);
      chk("t4_c6_pc", bus.pc, 32'h200);
      tick();                                  // cycle 7
      #1;
      chk("t4_c7_req", {31'd0, bus.imem_req}, 32'd1);
      chk("t4_c7_addr", bus.imem_addr, 32'h108);
      tick();                                  // cycle 8: ack of killed fetch
      bus.imem_ack   = 1'b1;
      bus.imem_rdata = 32'hDEAD_BEEF;
      #1;
      chk("t4_c8_addr", bus.imem_addr, 32'h108);
      tick();                                  // cycle 9
      bus.imem_ack = 1'b0;
      #1;
      chk("t4_c9_req", {31'd0, bus.imem_req}, 32'd1);
      chk("t4_c9_addr", bus.imem_addr, 32'h200);
      chk("t4_c9_valid", {31'd0, bus.instr_valid}, 32'd0);
      tick();
      #1;
      chk("t4_c10_valid", {31'd0, bus.instr_valid}, 32'd0);
      chk("t4_c10_instr", bus.instr, 32'h104 ^ K);

      // ---- 5: redirect coincident with ack of 0x10C
      do_reset();
      bus.instr_ready = 1'b1;
      bus.imem_ack    = 1'b1;
      bus.imem_rdata  = 32'h100 ^ K;
      tick();                                  // cycle 2
      bus.imem_rdata = 32'h104 ^ K;
      #1;
      chk("t5_c2_instr_pc", bus.instr_pc, 32'h100);
      tick();                                  // cycle 3
      bus.imem_rdata = 32'h108 ^ K;
      #1;
      chk("t5_c3_instr_pc", bus.instr_pc, 32'h104);
      tick();                                  // cycle 4
      bus.imem_rdata     = 32'h10C ^ K;
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = 32'h203;
      #1;
      chk("t5_c4_addr", bus.imem_addr, 32'h10C);
      chk("t5_c4_instr_pc", bus.instr_pc, 32'h108);
      tick();                                  // cycle 5
      bus.redirect_valid = 1'b0;
      bus.imem_rdata     = 32'h200 ^ K;
      #1;
      chk("t5_c5_req", {31'd0, bus.imem_req}, 32'd1);
      chk("t5_c5_addr", bus.imem_addr, 32'h200);
      chk("t5_c5_valid", {31'd0, bus.instr_valid}, 32'd0);
      chk("t5_c5_pc", bus.pc, 32'h200);

      // ---- 6: wrap across the top of the address space
      tick();                                  // cycle 6
      bus.imem_rdata     = 32'h204 ^ K;
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = 32'hFFFF_FFFC;
      #1;
      chk("t6_c6_instr_pc", bus.instr_pc, 32'h200);
      chk("t6_c6_addr", bus.imem_addr, 32'h204);
      tick();                                  // cycle 7
      bus.redirect_valid = 1'b0;
      bus.imem_rdata     = 32'hFFFF_FFFC ^ K;
      #1;
      chk("t6_c7_addr", bus.imem_addr, 32'hFFFF_FFFC);
      chk("t6_c7_valid", {31'd0, bus.instr_valid}, 32'd0);
      tick();                                  // cycle 8
      bus.imem_rdata = 32'h0 ^ K;
      #1;
      chk("t6_c8_instr_pc", bus.instr_pc, 32'hFFFF_FFFC);
      chk("t6_c8_instr", bus.instr, 32'hFFFF_FFFC ^ K);
      chk("t6_c8_addr", bus.imem_addr, 32'h0);
      chk("t6_c8_pc", bus.pc, 32'h0);
      tick();                                  // cycle 9
      bus.imem_ack = 1'b0;
      #1;
      chk("t6_c9_valid", {31'd0, bus.instr_valid}, 32'd1);
      chk("t6_c9_instr_pc", bus.instr_pc, 32'h0);
      chk("t6_c9_instr", bus.instr, K);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
